// File: rtl/vga_pkg.sv
// Shared constants, colour field layout, FSM state type and pixel
// packing for the VGA frame sequencer.
package vga_pkg;

  localparam int DEF_VGA_WIDTH  = 800;
  localparam int DEF_VGA_HEIGHT = 600;

  localparam int PX_W = 30;
  localparam int R_UI = 29;
  localparam int R_LI = 22;
  localparam int G_UI = 19;
  localparam int G_LI = 12;
  localparam int B_UI = 9;
  localparam int B_LI = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // 8-bit channels land in the top of each 10-bit stream field
  function automatic logic [PX_W-1:0] pack_px(input logic [23:0] rgb);
    logic [PX_W-1:0] p;
    p = '0;
    p[R_UI:R_LI] = rgb[23:16];
    p[G_UI:G_LI] = rgb[15:8];
    p[B_UI:B_LI] = rgb[7:0];
    return p;
  endfunction

endpackage

// File: rtl/vga_px_fifo.sv
// Registered synchronous pixel FIFO; data visible on dout one cycle
// after push, simultaneous push and pop keeps the count.
module vga_px_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Fetches one frame per packet from a double-buffered framebuffer and
// streams it out as a single SOP/EOP-framed Avalon-ST packet.
module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter int VGA_WIDTH  = DEF_VGA_WIDTH,
  parameter int VGA_HEIGHT = DEF_VGA_HEIGHT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] fb_base_a,
  input  logic [31:0] fb_base_b,
  input  logic        swap_req,
  output logic        front_sel,
  output logic        swap_done,
  output logic [31:0] mm_address,
  output logic        mm_read,
  input  logic        mm_waitrequest,
  input  logic [31:0] mm_readdata,
  input  logic        mm_readdatavalid,
  output logic [29:0] m_data,
  output logic        m_startofpacket,
  output logic        m_endofpacket,
  output logic        m_valid,
  output logic [1:0]  m_empty,
  input  logic        m_ready
);

  localparam int VGA_SIZE = VGA_WIDTH * VGA_HEIGHT;
  localparam int IW       = $clog2(VGA_SIZE+1);
  localparam int CW       = $clog2(FIFO_DEPTH+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(VGA_SIZE-1);
  localparam logic [CW:0]   CREDITS  = (CW+1)'(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic          front_q, front_d;
  logic          pend_q, pend_d;
  logic [31:0]   base_q, base_d;
  logic [IW-1:0] issue_q, issue_d;
  logic [IW-1:0] out_q, out_d;
  logic [CW-1:0] flight_q, flight_d;

  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic [23:0]   fifo_dout;
  logic          credit_ok;
  logic          rd_fire;
  logic          rsp_push;
  logic          beat_fire;
  logic          last_beat;
  logic          unused_ok;

  // Outstanding reads plus buffered pixels must fit the FIFO
  assign credit_ok = ({1'b0, flight_q} + {1'b0, fifo_cnt}) < CREDITS;
  assign mm_read   = (state_q == ST_RUN) & credit_ok;
  assign rd_fire   = mm_read & ~mm_waitrequest;
  assign rsp_push  = mm_readdatavalid & (flight_q != '0);
  assign beat_fire = m_valid & m_ready;
  assign last_beat = (out_q == LAST_IDX);

  assign mm_address      = base_q + (32'(issue_q) << 2);
  assign front_sel       = front_q;
  assign m_valid         = ~fifo_empty;
  assign m_data          = pack_px(fifo_dout);
  assign m_startofpacket = m_valid & (out_q == '0);
  assign m_endofpacket   = m_valid & last_beat;
  assign m_empty         = 2'b00;
  assign unused_ok       = ^{mm_readdata[31:24], fifo_full};

  vga_px_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_push),
    .pop   (beat_fire),
    .din   (mm_readdata[23:0]),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    pend_d    = pend_q | swap_req;
    base_d    = base_q;
    issue_d   = issue_q;
    out_d     = out_q;
    swap_done = 1'b0;
    flight_d  = flight_q + CW'(rd_fire) - CW'(rsp_push);
    if (beat_fire) out_d = out_q + IW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_START;
      end
      ST_START: begin
        if (pend_q | swap_req) begin
          front_d   = ~front_q;
          swap_done = 1'b1;
          pend_d    = 1'b0;
        end
        base_d  = front_d ? fb_base_b : fb_base_a;
        issue_d = '0;
        out_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rd_fire) begin
          issue_d = issue_q + IW'(1);
          if (issue_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_fire && last_beat)
          state_d = enable ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      front_q  <= 1'b0;
      pend_q   <= 1'b0;
      base_q   <= '0;
      issue_q  <= '0;
      out_q    <= '0;
      flight_q <= '0;
    end else begin
      state_q  <= state_d;
      front_q  <= front_d;
      pend_q   <= pend_d;
      base_q   <= base_d;
      issue_q  <= issue_d;
      out_q    <= out_d;
      flight_q <= flight_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboarded bench for vga_frame_sequencer on a 4x2 frame with a
// 4-entry FIFO and a configurable-latency Avalon-MM slave.
module tb_vga_frame_sequencer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;
  localparam int SIZE = W * H;
  localparam logic [31:0] BASE_A = 32'h0010_0000;
  localparam logic [31:0] BASE_B = 32'h0020_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        swap_req = 1'b0;
  logic [31:0] fb_base_a = BASE_A;
  logic [31:0] fb_base_b = BASE_B;
  logic        front_sel;
  logic        swap_done;
  logic [31:0] mm_address;
  logic        mm_read;
  logic        mm_waitrequest = 1'b0;
  logic [31:0] mm_readdata = '0;
  logic        mm_readdatavalid = 1'b0;
  logic [29:0] m_data;
  logic        m_startofpacket;
  logic        m_endofpacket;
  logic        m_valid;
  logic [1:0]  m_empty;
  logic        m_ready = 1'b0;

  vga_frame_sequencer #(
    .VGA_WIDTH  (W),
    .VGA_HEIGHT (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .fb_base_a        (fb_base_a),
    .fb_base_b        (fb_base_b),
    .swap_req         (swap_req),
    .front_sel        (front_sel),
    .swap_done        (swap_done),
    .mm_address       (mm_address),
    .mm_read          (mm_read),
    .mm_waitrequest   (mm_waitrequest),
    .mm_readdata      (mm_readdata),
    .mm_readdatavalid (mm_readdatavalid),
    .m_data           (m_data),
    .m_startofpacket  (m_startofpacket),
    .m_endofpacket    (m_endofpacket),
    .m_valid          (m_valid),
    .m_empty          (m_empty),
    .m_ready          (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] pix;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  beat_t       exp_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] base_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 0;
  int wait_pct = 0;
  int ready_pct = 100;
  int exp_idx = 0;
  int frames_started = 0;
  int frames_done = 0;
  int beats = 0;
  int reads_total = 0;
  int swaps = 0;
  int first_read_cyc = -1;
  int first_rdv_cyc = -1;
  int first_valid_cyc = -1;
  int sop_cyc = 0;
  int eop_cyc = 0;
  int last_eop_cyc = -100;
  int sop_gap = -1;
  logic        stall_q = 1'b0;
  logic [31:0] stall_addr = '0;
  logic [31:0] cur_base = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:8] ^ 8'hA5, a[23:0] ^ 24'h5A3C96};
  endfunction

  function automatic logic [29:0] exp_pix(input logic [31:0] w);
    return {w[23:16], 2'b00, w[15:8], 2'b00, w[7:0], 2'b00};
  endfunction

  // Slave, stream sink and scoreboard, all evaluated at the falling edge
  initial begin
    rsp_t        r;
    beat_t       e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (stall_q) begin
          total++;
          if (mm_read !== 1'b1 || mm_address !== stall_addr) begin
            bad++;
            $display("FAIL stall_hold: read=%b addr=%h required read=1 addr=%h",
                     mm_read, mm_address, stall_addr);
          end
        end
        if (mm_read === 1'b1 && first_read_cyc < 0) first_read_cyc = cyc;
        mm_waitrequest = ($urandom_range(99) < wait_pct);
        stall_q = mm_read & mm_waitrequest;
        stall_addr = mm_address;
        if (mm_read === 1'b1 && !mm_waitrequest) begin
          if (exp_idx == 0) begin
            if (base_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_frame: read at %h with no frame due", mm_address);
              cur_base = mm_address;
            end else begin
              cur_base = base_q.pop_front();
            end
            frames_started++;
          end
          ea = cur_base + 32'(exp_idx * 4);
          total++;
          if (mm_address !== ea) begin
            bad++;
            $display("FAIL read_addr: got %h required %h", mm_address, ea);
          end
          rsp_q.push_back('{addr: mm_address, due: cyc + lat + 1});
          exp_q.push_back('{pix: exp_pix(mem_word(ea)),
                            sop: (exp_idx == 0), eop: (exp_idx == SIZE-1)});
          exp_idx = (exp_idx == SIZE-1) ? 0 : exp_idx + 1;
          reads_total++;
        end
        m_ready = ($urandom_range(99) < ready_pct);
        if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid === 1'b1 && m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: data=%h with nothing expected", m_data);
          end else begin
            e = exp_q.pop_front();
            total++;
            if (m_data !== e.pix || m_startofpacket !== e.sop ||
                m_endofpacket !== e.eop) begin
              bad++;
              $display("FAIL beat: got %h sop=%b eop=%b required %h sop=%b eop=%b",
                       m_data, m_startofpacket, m_endofpacket, e.pix, e.sop, e.eop);
            end
            beats++;
            if (e.sop) begin
              sop_gap = cyc - last_eop_cyc;
              sop_cyc = cyc;
            end
            if (e.eop) begin
              last_eop_cyc = cyc;
              eop_cyc = cyc;
              frames_done++;
            end
          end
        end
        total++;
        if (exp_q.size() > D) begin
          bad++;
          $display("FAIL credit: outstanding=%0d required <= %0d", exp_q.size(), D);
        end
      end else begin
        stall_q = 1'b0;
        mm_waitrequest = 1'b0;
        m_ready = 1'b0;
      end
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        mm_readdatavalid = 1'b1;
        mm_readdata = mem_word(r.addr);
        if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
      end else begin
        mm_readdatavalid = 1'b0;
        mm_readdata = $urandom;
      end
      if (swap_done === 1'b1) swaps++;
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input int sel, input int target,
                          input int budget, output bit ok);
    int v;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      case (sel)
        0: v = frames_started;
        1: v = frames_done;
        default: v = beats;
      endcase
      if (v >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if ({mm_read, m_valid, m_startofpacket, m_endofpacket, swap_done, front_sel} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {mm_read, m_valid, m_startofpacket, m_endofpacket, swap_done, front_sel});
    end
    total++;
    if (mm_address !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr: got %h required 0", mm_address);
    end
    total++;
    if (m_empty !== 2'b00) begin
      bad++;
      $display("FAIL m_empty: got %b required 00", m_empty);
    end
    cycles(3);
    reset = 1'b0;
    cycles(4);
    total++;
    if (mm_read !== 1'b0 || reads_total != 0) begin
      bad++;
      $display("FAIL idle_no_read: read=%b reads=%0d required 0", mm_read, reads_total);
    end
  endtask

  task automatic test_basic();
    int t0, b0, f0, s0;
    bit ok;
    lat = 0; wait_pct = 0; ready_pct = 100;
    b0 = beats; f0 = frames_done; s0 = frames_started;
    base_q.push_back(BASE_A);
    first_read_cyc = -1; first_rdv_cyc = -1; first_valid_cyc = -1;
    t0 = cyc;
    enable = 1'b1;
    wait_for(0, s0 + 1, 50, ok);
    enable = 1'b0;
    wait_for(1, f0 + 1, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: frames=%0d required %0d", frames_done, f0 + 1); end
    total++;
    if (first_read_cyc != t0 + 1) begin
      bad++;
      $display("FAIL start_latency: first read cycle %0d required %0d", first_read_cyc, t0 + 1);
    end
    total++;
    if (first_valid_cyc != first_rdv_cyc + 1) begin
      bad++;
      $display("FAIL valid_latency: m_valid at %0d required %0d", first_valid_cyc, first_rdv_cyc + 1);
    end
    total++;
    if (eop_cyc - sop_cyc != SIZE - 1) begin
      bad++;
      $display("FAIL throughput: sop-eop span %0d required %0d", eop_cyc - sop_cyc, SIZE - 1);
    end
    total++;
    if (beats - b0 != SIZE) begin
      bad++;
      $display("FAIL basic_beats: got %0d required %0d", beats - b0, SIZE);
    end
  endtask

  task automatic test_latency_stall();
    int b0, f0, s0, r0;
    bit ok;
    lat = 3; wait_pct = 40; ready_pct = 100;
    b0 = beats; f0 = frames_done; s0 = frames_started; r0 = reads_total;
    base_q.push_back(BASE_A);
    enable = 1'b1;
    wait_for(0, s0 + 1, 100, ok);
    enable = 1'b0;
    wait_for(1, f0 + 1, 400, ok);
    total++;
    if (!ok || beats - b0 != SIZE || reads_total - r0 != SIZE) begin
      bad++;
      $display("FAIL latency_frame: beats=%0d reads=%0d required %0d each",
               beats - b0, reads_total - r0, SIZE);
    end
  endtask

  task automatic test_ready_toggle();
    int b0, f0, s0;
    bit ok;
    lat = 2; wait_pct = 20; ready_pct = 50;
    b0 = beats; f0 = frames_done; s0 = frames_started;
    base_q.push_back(BASE_A);
    base_q.push_back(BASE_A);
    enable = 1'b1;
    wait_for(0, s0 + 2, 400, ok);
    enable = 1'b0;
    wait_for(1, f0 + 2, 600, ok);
    total++;
    if (!ok || beats - b0 != 2 * SIZE) begin
      bad++;
      $display("FAIL ready_toggle: beats=%0d required %0d", beats - b0, 2 * SIZE);
    end
    ready_pct = 100;
  endtask

  task automatic test_back_to_back();
    int b0, f0, s0;
    bit ok;
    lat = 0; wait_pct = 0; ready_pct = 100;
    b0 = beats; f0 = frames_done; s0 = frames_started;
    base_q.push_back(BASE_A);
    base_q.push_back(BASE_A);
    enable = 1'b1;
    wait_for(0, s0 + 2, 200, ok);
    enable = 1'b0;
    wait_for(1, f0 + 2, 300, ok);
    total++;
    if (!ok || beats - b0 != 2 * SIZE) begin
      bad++;
      $display("FAIL b2b_beats: beats=%0d required %0d", beats - b0, 2 * SIZE);
    end
    total++;
    if (sop_gap != 4) begin
      bad++;
      $display("FAIL b2b_gap: eop-to-sop %0d cycles required 4", sop_gap);
    end
  endtask

  task automatic test_swap();
    int b0, f0, s0, w0;
    bit ok;
    lat = 1; wait_pct = 0; ready_pct = 100;
    b0 = beats; f0 = frames_done; s0 = frames_started; w0 = swaps;
    base_q.push_back(BASE_A);
    base_q.push_back(BASE_B);
    enable = 1'b1;
    wait_for(2, b0 + 1, 100, ok);
    swap_req = 1'b1;
    cycles(1);
    swap_req = 1'b0;
    cycles(1);
    swap_req = 1'b1;
    cycles(1);
    swap_req = 1'b0;
    total++;
    if (front_sel !== 1'b0 || swaps != w0) begin
      bad++;
      $display("FAIL swap_early: front=%b swaps=%0d required 0 and 0", front_sel, swaps - w0);
    end
    wait_for(0, s0 + 2, 200, ok);
    enable = 1'b0;
    wait_for(1, f0 + 2, 300, ok);
    total++;
    if (!ok || front_sel !== 1'b1 || swaps - w0 != 1) begin
      bad++;
      $display("FAIL swap_done: front=%b swaps=%0d required 1 and 1", front_sel, swaps - w0);
    end
  endtask

  task automatic test_enable_drop();
    int b0, f0, r0;
    bit ok;
    lat = 1; wait_pct = 0; ready_pct = 100;
    b0 = beats; f0 = frames_done; r0 = reads_total;
    base_q.push_back(BASE_B);
    enable = 1'b1;
    wait_for(2, b0 + 3, 100, ok);
    enable = 1'b0;
    wait_for(1, f0 + 1, 200, ok);
    cycles(15);
    total++;
    if (!ok || beats - b0 != SIZE || reads_total - r0 != SIZE) begin
      bad++;
      $display("FAIL enable_drop: beats=%0d reads=%0d required %0d each",
               beats - b0, reads_total - r0, SIZE);
    end
    total++;
    if (mm_read !== 1'b0 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL enable_idle: read=%b valid=%b required 0 0", mm_read, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    int b0, f0, s0, stale;
    bit ok;
    lat = 3; wait_pct = 0; ready_pct = 100;
    b0 = beats; s0 = frames_started;
    base_q.push_back(BASE_B);
    enable = 1'b1;
    wait_for(2, b0 + 5, 200, ok);
    @(posedge clk);
    #1;
    stale = rsp_q.size();
    reset = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    base_q.delete();
    exp_idx = 0;
    stall_q = 1'b0;
    #1;
    total++;
    if (stale == 0) begin
      bad++;
      $display("FAIL reset_outstanding: got %0d reads in flight required > 0", stale);
    end
    total++;
    if ({mm_read, m_valid, m_startofpacket, m_endofpacket, front_sel} !== 5'b0 ||
        mm_address !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: ctrl=%b addr=%h required 00000 and 0",
               {mm_read, m_valid, m_startofpacket, m_endofpacket, front_sel}, mm_address);
    end
    cycles(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      total++;
      if (m_valid !== 1'b0) begin
        bad++;
        $display("FAIL stale_data: m_valid=%b data=%h required valid 0", m_valid, m_data);
      end
    end
    b0 = beats; f0 = frames_done; s0 = frames_started;
    base_q.push_back(BASE_A);
    enable = 1'b1;
    wait_for(0, s0 + 1, 50, ok);
    enable = 1'b0;
    wait_for(1, f0 + 1, 300, ok);
    total++;
    if (!ok || beats - b0 != SIZE || exp_q.size() != 0) begin
      bad++;
      $display("FAIL post_reset_frame: beats=%0d left=%0d required %0d and 0",
               beats - b0, exp_q.size(), SIZE);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency_stall();
    test_ready_toggle();
    test_back_to_back();
    test_swap();
    test_enable_drop();
    test_reset_mid();
    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
